// File: rtl/pll_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL supervisor / reset sequencer:
//   - seq_state_t : 3-bit state codes (6 and 7 are unused and recover to PLL_RST)
//   - DEF_*       : default timing constants, in 50 MHz reference-clock cycles
//   - helpers     : reset decode and lock-loss accounting per state
// -----------------------------------------------------------------------------
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_MEM_INIT  = 3'd3,
      ST_RUN       = 3'd4,
      ST_SOFT      = 3'd5
   } seq_state_t;

   localparam int DEF_RST_CYCLES    = 16;       // PLL reset pulse per attempt
   localparam int DEF_LOCK_TIMEOUT  = 1000000;  // 20 ms at 50 MHz
   localparam int DEF_STABLE_CYCLES = 4096;     // continuous lock before mem_rst release
   localparam int DEF_MEM_WAIT      = 65535;    // max wait for SDRAM init
   localparam int DEF_SOFT_CYCLES   = 256;      // core_rst pulse for a soft reset
   localparam int DEF_CNT_W         = 20;       // must hold the largest constant above

   // The SDRAM controller stays in reset until the lock has been proven stable.
   function automatic logic mem_rst_for(input seq_state_t s);
      return (s == ST_PLL_RST) || (s == ST_WAIT_LOCK) || (s == ST_STABLE);
   endfunction

   // Only losses after the system was released are counted.
   function automatic logic counts_lock_loss(input seq_state_t s);
      return (s == ST_RUN) || (s == ST_SOFT);
   endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for slow asynchronous status levels.
// Ports:
//   i_clk  in  destination clock
//   i_rst  in  synchronous active-high reset (clears both stages)
//   i_d    in  asynchronous input, W bits
//   o_q    out synchronised output, 2 cycles of latency
// -----------------------------------------------------------------------------
module sync2 #(
   parameter int W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= '0;
         r_q    <= '0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
// Supervises the video/SDRAM PLL from the free-running 50 MHz reference clock
// and sequences the PLL, SDRAM-controller and core resets from its lock status.
// Ports:
//   i_clk            in   50 MHz reference clock
//   i_rst            in   synchronous active-high board/power-on reset
//   i_pll_locked     in   PLL lock flag, asynchronous (synchronised here)
//   i_mem_init_done  in   SDRAM init complete, already synchronous
//   i_soft_rst_req   in   OSD/user soft-reset request, level
//   o_pll_rst        out  reset to the PLL
//   o_mem_rst        out  SDRAM controller reset
//   o_core_rst       out  CPU/video/sound reset
//   o_ready          out  high only in RUN
//   o_state          out  current state code
//   o_lock_loss_cnt  out  saturating count of lock losses in RUN/SOFT
// -----------------------------------------------------------------------------
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int MEM_WAIT      = DEF_MEM_WAIT,
   parameter int SOFT_CYCLES   = DEF_SOFT_CYCLES,
   parameter int CNT_W         = DEF_CNT_W
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_pll_locked,
   input  logic       i_mem_init_done,
   input  logic       i_soft_rst_req,
   output logic       o_pll_rst,
   output logic       o_mem_rst,
   output logic       o_core_rst,
   output logic       o_ready,
   output logic [2:0] o_state,
   output logic [7:0] o_lock_loss_cnt
);

   localparam logic [CNT_W-1:0] C_RST_LOAD    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_LOCK_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] C_STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] C_MEM_LOAD    = CNT_W'(MEM_WAIT);
   localparam logic [CNT_W-1:0] C_SOFT_LOAD   = CNT_W'(SOFT_CYCLES - 1);

   logic             w_lk_s;
   seq_state_t       r_state;
   seq_state_t       w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_cnt_zero;
   logic             w_loss;
   logic [7:0]       r_loss_cnt;
   logic             r_pll_rst;
   logic             r_mem_rst;
   logic             r_core_rst;
   logic             r_ready;

   sync2 #(
      .W (1)
   ) u_lock_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_pll_locked),
      .o_q   (w_lk_s)
   );

   assign w_cnt_zero = (r_cnt == '0);

   // One shared down-counter: every timed state loads it on entry and counts
   // down to zero; states that do not time anything simply hold it.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt - CNT_W'(1);
      w_loss       = 1'b0;
      case (r_state)
         ST_PLL_RST: begin
            if (w_cnt_zero) begin
               w_state_next = ST_WAIT_LOCK;
               w_cnt_next   = C_LOCK_LOAD;
            end
         end
         ST_WAIT_LOCK: begin
            if (w_lk_s) begin
               w_state_next = ST_STABLE;
               w_cnt_next   = C_STABLE_LOAD;
            end else if (w_cnt_zero) begin
               w_state_next = ST_PLL_RST;
               w_cnt_next   = C_RST_LOAD;
            end
         end
         ST_STABLE: begin
            if (!w_lk_s) begin
               w_state_next = ST_WAIT_LOCK;
               w_cnt_next   = C_LOCK_LOAD;
            end else if (w_cnt_zero) begin
               w_state_next = ST_MEM_INIT;
               w_cnt_next   = C_MEM_LOAD;
            end
         end
         ST_MEM_INIT: begin
            if (!w_lk_s) begin
               w_state_next = ST_WAIT_LOCK;
               w_cnt_next   = C_LOCK_LOAD;
            end else if (i_mem_init_done || w_cnt_zero) begin
               // A timeout still releases the core; the SDRAM controller
               // is expected to report its own failure.
               w_state_next = ST_RUN;
               w_cnt_next   = r_cnt;
            end
         end
         ST_RUN: begin
            w_cnt_next = r_cnt;
            if (!w_lk_s) begin
               w_state_next = ST_WAIT_LOCK;
               w_cnt_next   = C_LOCK_LOAD;
            end else if (i_soft_rst_req) begin
               w_state_next = ST_SOFT;
               w_cnt_next   = C_SOFT_LOAD;
            end
         end
         ST_SOFT: begin
            if (!w_lk_s) begin
               w_state_next = ST_WAIT_LOCK;
               w_cnt_next   = C_LOCK_LOAD;
            end else if (w_cnt_zero) begin
               // Park at zero while the request is still held.
               w_cnt_next = r_cnt;
               if (!i_soft_rst_req) begin
                  w_state_next = ST_RUN;
               end
            end
         end
         default: begin
            w_state_next = ST_PLL_RST;
            w_cnt_next   = C_RST_LOAD;
         end
      endcase
      w_loss = !w_lk_s && counts_lock_loss(r_state);
   end

   // Resets are decoded from the next state so they switch on the same edge
   // as the state register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_PLL_RST;
         r_cnt      <= C_RST_LOAD;
         r_pll_rst  <= 1'b1;
         r_mem_rst  <= 1'b1;
         r_core_rst <= 1'b1;
         r_ready    <= 1'b0;
         r_loss_cnt <= 8'd0;
      end else begin
         r_state    <= w_state_next;
         r_cnt      <= w_cnt_next;
         r_pll_rst  <= (w_state_next == ST_PLL_RST);
         r_mem_rst  <= mem_rst_for(w_state_next);
         r_core_rst <= (w_state_next != ST_RUN);
         r_ready    <= (w_state_next == ST_RUN);
         if (w_loss && (r_loss_cnt != 8'hFF)) begin
            r_loss_cnt <= r_loss_cnt + 8'd1;
         end
      end
   end

   assign o_pll_rst       = r_pll_rst;
   assign o_mem_rst       = r_mem_rst;
   assign o_core_rst      = r_core_rst;
   assign o_ready         = r_ready;
   assign o_state         = r_state;
   assign o_lock_loss_cnt = r_loss_cnt;

endmodule
